// File: rtl/np_bridge_pkg.sv
// Shared opcodes, status codes and FSM encoding for the byte-stream iomem bridge.
// Purely declarative: no logic, no latency, no flow control.
package np_bridge_pkg;

  localparam logic [7:0] OP_WRITE   = 8'h57;
  localparam logic [7:0] OP_READ    = 8'h52;
  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_TIMEOUT = 8'hFF;
  localparam logic [7:0] ST_BADCMD  = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_BUS  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  function automatic logic [31:0] shift_in(input logic [31:0] word, input logic [7:0] b);
    return {word[23:0], b};
  endfunction

endpackage

// File: rtl/np_iomem_bridge_if.sv
// Bundles the rx byte stream, tx byte stream and iomem initiator signals of the bridge.
// master = bridge side, slave = environment (uart, responder, tx sink).
interface np_iomem_bridge_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, iomem_ready, iomem_rdata,
    output rx_ready, tx_data, tx_valid, iomem_valid, iomem_wstrb,
           iomem_addr, iomem_wdata, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, iomem_ready, iomem_rdata,
    input  rx_ready, tx_data, tx_valid, iomem_valid, iomem_wstrb,
           iomem_addr, iomem_wdata, busy
  );

endinterface

// File: rtl/np_bridge_txser.sv
// Response serializer: loads 1 or 5 bytes, first byte valid the cycle after load.
// Holds o_dat/o_vld until i_rdy; back-to-back bytes with no bubble while i_rdy stays high.
module np_bridge_txser (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_load,
  input  logic        i_len5,
  input  logic [39:0] i_dat,
  input  logic        i_rdy,
  output logic [7:0]  o_dat,
  output logic        o_vld,
  output logic        o_done
);

  logic [39:0] r_buf;
  logic [2:0]  r_left;
  logic        w_fire;

  assign o_vld  = (r_left != 3'd0);
  assign o_dat  = r_buf[39:32];
  assign w_fire = o_vld & i_rdy;
  assign o_done = w_fire & (r_left == 3'd1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_buf  <= '0;
      r_left <= '0;
    end else if (i_load) begin
      r_buf  <= i_dat;
      r_left <= i_len5 ? 3'd5 : 3'd1;
    end else if (w_fire) begin
      r_buf  <= {r_buf[31:0], 8'h00};
      r_left <= r_left - 3'd1;
    end
  end

endmodule

// File: rtl/np_iomem_bridge.sv
// Byte-command to iomem initiator: parse W/R command, run one bus cycle with timeout, reply status(+rdata).
// rx stalls (rx_ready=0) during BUS/RESP; tx bytes held until tx_ready; first reply byte one cycle after ready/abort.
module np_iomem_bridge
  import np_bridge_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 16
) (
  input logic               CLK,
  input logic               RST,
  np_iomem_bridge_if.master bus
);

  state_t          r_state;
  logic            r_armed;
  logic [7:0]      r_op;
  logic [1:0]      r_cnt;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [TO_W-1:0] r_to;

  logic       w_rx_fire;
  logic       w_op_ok;
  logic       w_timeout;
  logic       w_bus_ok;
  logic       w_bus_abort;
  logic       w_bad;
  logic       w_load;
  logic       w_len5;
  logic       w_tx_done;
  logic [7:0] w_status;

  assign bus.rx_ready = r_armed &
                        ((r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_DATA));
  assign w_rx_fire    = bus.rx_valid & bus.rx_ready;
  assign w_op_ok      = (bus.rx_data == OP_WRITE) || (bus.rx_data == OP_READ);
  assign w_timeout    = (r_to == TO_W'(TIMEOUT));

  // Ready beats the timeout when both land in the same cycle.
  assign w_bus_ok    = (r_state == S_BUS) & bus.iomem_ready;
  assign w_bus_abort = (r_state == S_BUS) & ~bus.iomem_ready & w_timeout;
  assign w_bad       = (r_state == S_IDLE) & w_rx_fire & ~w_op_ok;
  assign w_load      = w_bus_ok | w_bus_abort | w_bad;
  assign w_len5      = w_bus_ok & (r_op == OP_READ);

  always_comb begin
    w_status = ST_BADCMD;
    if (w_bus_ok)         w_status = ST_OK;
    else if (w_bus_abort) w_status = ST_TIMEOUT;
  end

  assign bus.iomem_valid = (r_state == S_BUS);
  assign bus.iomem_addr  = r_addr;
  assign bus.iomem_wdata = r_wdata;
  assign bus.iomem_wstrb = ((r_state == S_BUS) && (r_op == OP_WRITE)) ? 4'hF : 4'h0;
  assign bus.busy        = (r_state != S_IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_armed <= 1'b0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_to    <= '0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_rx_fire) begin
            r_op    <= bus.rx_data;
            r_cnt   <= 2'd0;
            r_state <= w_op_ok ? S_ADDR : S_RESP;
          end
        end
        S_ADDR: begin
          if (w_rx_fire) begin
            r_addr <= shift_in(r_addr, bus.rx_data);
            r_cnt  <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              if (r_op == OP_WRITE) begin
                r_state <= S_DATA;
              end else begin
                r_state <= S_BUS;
                r_to    <= '0;
              end
            end
          end
        end
        S_DATA: begin
          if (w_rx_fire) begin
            r_wdata <= shift_in(r_wdata, bus.rx_data);
            r_cnt   <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state <= S_BUS;
              r_to    <= '0;
            end
          end
        end
        S_BUS: begin
          if (bus.iomem_ready || w_timeout) r_state <= S_RESP;
          else                              r_to    <= r_to + TO_W'(1);
        end
        S_RESP: begin
          if (w_tx_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  np_bridge_txser u_txser (
    .CLK    (CLK),
    .RST    (RST),
    .i_load (w_load),
    .i_len5 (w_len5),
    .i_dat  ({w_status, bus.iomem_rdata}),
    .i_rdy  (bus.tx_ready),
    .o_dat  (bus.tx_data),
    .o_vld  (bus.tx_valid),
    .o_done (w_tx_done)
  );

endmodule

// File: tb/tb_np_iomem_bridge.sv
// Directed bench for np_iomem_bridge: write, read-back with tx backpressure, timeout, bad command, mid-bus reset.
module tb_np_iomem_bridge;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  np_iomem_bridge_if bif ();

  np_iomem_bridge #(.TIMEOUT(4), .TO_W(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bif)
  );

  int errors = 0;
  int checks = 0;

  int          resp_delay = -1;
  int          vhigh = 0;
  int          xfers = 0;
  int          bus_unstable = 0;
  logic [31:0] cap_addr = '0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;
  logic [31:0] gpio_word = '0;

  int         bp_hold = 0;
  int         bp_cnt = 0;
  logic [7:0] txq[$];
  int         tx_unstable = 0;
  int         rx_overlap = 0;
  logic       tx_stalled = 1'b0;
  logic [7:0] tx_prev = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] txb(input int i);
    if (i < txq.size()) return txq[i];
    return 8'hxx;
  endfunction

  // Responder and tx sink, both acting on the falling edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (bif.iomem_ready) begin
        bif.iomem_ready = 1'b0;
        bif.iomem_rdata = 32'hDEAD_BEEF;
      end
      if (bif.iomem_valid) begin
        if (bif.rx_ready) rx_overlap++;
        if (vhigh == 0) begin
          cap_addr  = bif.iomem_addr;
          cap_wdata = bif.iomem_wdata;
          cap_wstrb = bif.iomem_wstrb;
        end else if (cap_addr !== bif.iomem_addr || cap_wdata !== bif.iomem_wdata ||
                     cap_wstrb !== bif.iomem_wstrb) begin
          bus_unstable++;
        end
        vhigh++;
        if (resp_delay >= 0 && vhigh == resp_delay + 1) begin
          bif.iomem_ready = 1'b1;
          bif.iomem_rdata = gpio_word;
          xfers++;
          if (bif.iomem_wstrb == 4'hF) gpio_word = bif.iomem_wdata;
        end
      end
      if (bif.tx_valid) begin
        if (tx_stalled && bif.tx_data !== tx_prev) tx_unstable++;
        if (bif.rx_ready) rx_overlap++;
        if (bp_cnt < bp_hold) begin
          bif.tx_ready = 1'b0;
          bp_cnt++;
        end else begin
          bif.tx_ready = 1'b1;
          bp_cnt = 0;
          txq.push_back(bif.tx_data);
        end
        tx_stalled = !bif.tx_ready;
        tx_prev    = bif.tx_data;
      end else begin
        bif.tx_ready = (bp_hold == 0);
        tx_stalled   = 1'b0;
      end
    end
  end

  task automatic send_cmd(input logic [71:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      int w;
      w = 0;
      bif.rx_data  = v[8*i +: 8];
      bif.rx_valid = 1'b1;
      while (!bif.rx_ready && w < 200) begin
        @(negedge CLK);
        w++;
      end
      check("rx_accept", (w < 200), 1);
      @(negedge CLK);
      bif.rx_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge CLK);
    while ((bif.busy || bif.tx_valid) && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    check("wait_done", (n < 3000), 1);
  endtask

  task automatic clear_obs();
    vhigh = 0;
    xfers = 0;
    bus_unstable = 0;
    tx_unstable = 0;
    rx_overlap = 0;
    bp_cnt = 0;
    txq.delete();
  endtask

  initial begin
    bif.rx_data     = '0;
    bif.rx_valid    = 1'b0;
    bif.tx_ready    = 1'b0;
    bif.iomem_ready = 1'b0;
    bif.iomem_rdata = '0;

    #12;
    check("rst_rx_ready", bif.rx_ready, 0);
    check("rst_tx_valid", bif.tx_valid, 0);
    check("rst_iomem_valid", bif.iomem_valid, 0);
    check("rst_busy", bif.busy, 0);
    check("rst_addr_wdata", {bif.iomem_addr, bif.iomem_wdata}, 0);
    check("rst_wstrb_txdata", {bif.iomem_wstrb, bif.tx_data}, 0);
    @(negedge CLK);
    RST = 1'b1;
    #1 check("arm_before_edge", bif.rx_ready, 0);
    @(negedge CLK);
    check("arm_after_edge", bif.rx_ready, 1);

    // Write 0xA5 to gpio, responder ready two cycles after valid
    clear_obs();
    resp_delay = 2;
    bp_hold = 0;
    send_cmd(72'h57_03000000_000000A5, 9);
    wait_done();
    check("t1_xfers", xfers, 1);
    check("t1_addr", cap_addr, 32'h0300_0000);
    check("t1_wdata", cap_wdata, 32'h0000_00A5);
    check("t1_wstrb", cap_wstrb, 4'hF);
    check("t1_vhigh", vhigh, 3);
    check("t1_bus_stable", bus_unstable, 0);
    check("t1_txlen", txq.size(), 1);
    check("t1_tx0", txb(0), 8'h00);

    // Read back under heavy tx backpressure
    clear_obs();
    bp_hold = 10;
    send_cmd(72'h52_03000000, 5);
    wait_done();
    check("t2_xfers", xfers, 1);
    check("t2_addr", cap_addr, 32'h0300_0000);
    check("t2_wstrb", cap_wstrb, 4'h0);
    check("t2_vhigh", vhigh, 3);
    check("t2_txlen", txq.size(), 5);
    check("t2_tx", {txb(0), txb(1), txb(2), txb(3), txb(4)}, 40'h00_000000A5);
    check("t5_tx_stable", tx_unstable, 0);
    check("t5_rx_blocked", rx_overlap, 0);

    // Responder never answers: abort after TIMEOUT+1 valid cycles
    clear_obs();
    bp_hold = 0;
    resp_delay = -1;
    send_cmd(72'h52_04000000, 5);
    wait_done();
    check("t3_vhigh", vhigh, 5);
    check("t3_xfers", xfers, 0);
    check("t3_addr", cap_addr, 32'h0400_0000);
    check("t3_txlen", txq.size(), 1);
    check("t3_tx0", txb(0), 8'hFF);
    check("t3_valid_low", bif.iomem_valid, 0);

    // Unknown opcode, then a normal read right after
    clear_obs();
    resp_delay = 0;
    send_cmd(72'h41, 1);
    wait_done();
    check("t4_vhigh", vhigh, 0);
    check("t4_txlen", txq.size(), 1);
    check("t4_tx0", txb(0), 8'hEE);
    clear_obs();
    send_cmd(72'h52_03000000, 5);
    wait_done();
    check("t4b_vhigh", vhigh, 1);
    check("t4b_txlen", txq.size(), 5);
    check("t4b_tx", {txb(0), txb(1), txb(2), txb(3), txb(4)}, 40'h00_000000A5);

    // Reset while the bus request is outstanding
    clear_obs();
    resp_delay = -1;
    gpio_word = '0;
    send_cmd(72'h52_03000000, 5);
    check("t6_in_bus", bif.iomem_valid, 1);
    @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    check("t6_async_valid", bif.iomem_valid, 0);
    check("t6_async_busy", bif.busy, 0);
    check("t6_async_rx", bif.rx_ready, 0);
    @(negedge CLK);
    RST = 1'b1;
    #1 check("t6_rearm_before", bif.rx_ready, 0);
    @(negedge CLK);
    check("t6_rearm_after", bif.rx_ready, 1);
    clear_obs();
    resp_delay = 2;
    send_cmd(72'h57_03000000_000000A5, 9);
    wait_done();
    check("t6_xfers", xfers, 1);
    check("t6_wdata", cap_wdata, 32'h0000_00A5);
    check("t6_vhigh", vhigh, 3);
    check("t6_tx", {txq.size() == 1, txb(0)}, {1'b1, 8'h00});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
